// File: rtl/mem_pkg.sv
// Shared memory-request definitions for the Dcache port arbiter.
// Contents: request FSM state encoding, address/tag widths, quadword offset.
package mem_pkg;

  localparam int unsigned MEM_ADDR_W = 64;
  localparam int unsigned PR_IDX_W   = 7;
  localparam int unsigned AR_IDX_W   = 5;
  // Lowest address bit that distinguishes quadwords (8-byte granules).
  localparam int unsigned QW_LSB     = 3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LD_WAIT = 2'd1,
    ST_WAIT = 2'd2
  } req_state_e;

endpackage

// File: rtl/stb_fifo.sv
// Retire-store buffer: circular FIFO of (address, data) entries.
// Ports:
//   clock, reset       - clock, asynchronous active-low reset
//   i_push/i_push_*    - enqueue a retired store (dropped when full)
//   i_pop              - dequeue the head entry
//   i_cmp_en/i_cmp_qw  - quadword address to compare against all valid entries
//   o_head_*           - head entry contents
//   o_count/o_full/o_empty - occupancy (registered)
//   o_conflict         - compare address matches a valid entry
module stb_fifo
  import mem_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           i_push,
  input  logic [MEM_ADDR_W-1:0]          i_push_addr,
  input  logic [MEM_ADDR_W-1:0]          i_push_value,
  input  logic                           i_pop,
  input  logic                           i_cmp_en,
  input  logic [MEM_ADDR_W-1:QW_LSB]     i_cmp_qw,
  output logic [MEM_ADDR_W-1:0]          o_head_addr,
  output logic [MEM_ADDR_W-1:0]          o_head_value,
  output logic [$clog2(DEPTH):0]         o_count,
  output logic                           o_full,
  output logic                           o_empty,
  output logic                           o_conflict
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [MEM_ADDR_W-1:0] r_addr  [DEPTH];
  logic [MEM_ADDR_W-1:0] r_value [DEPTH];
  logic [DEPTH-1:0]      r_valid;
  logic [PTR_W-1:0]      r_head;
  logic [PTR_W-1:0]      r_tail;
  logic [PTR_W:0]        r_count;
  logic                  r_full;

  logic                  w_push;
  logic                  w_pop;
  logic [PTR_W:0]        w_count_d;
  logic                  w_match;

  assign w_push = i_push & ~r_full;
  assign w_pop  = i_pop & (r_count != '0);

  always_comb begin
    w_count_d = r_count;
    unique case ({w_push, w_pop})
      2'b10:   w_count_d = r_count + 1'b1;
      2'b01:   w_count_d = r_count - 1'b1;
      default: w_count_d = r_count;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_addr[i]  <= '0;
        r_value[i] <= '0;
      end
      r_valid <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_full  <= 1'b0;
    end else begin
      // Pop clears before push sets so a same-slot push/pop (full drain) stays correct.
      if (w_pop) begin
        r_valid[r_head] <= 1'b0;
        r_head          <= r_head + 1'b1;
      end
      if (w_push) begin
        r_addr[r_tail]  <= i_push_addr;
        r_value[r_tail] <= i_push_value;
        r_valid[r_tail] <= 1'b1;
        r_tail          <= r_tail + 1'b1;
      end
      r_count <= w_count_d;
      r_full  <= (w_count_d == (PTR_W + 1)'(DEPTH));
    end
  end

  always_comb begin
    w_match = 1'b0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (r_valid[i] && (r_addr[i][MEM_ADDR_W-1:QW_LSB] == i_cmp_qw)) begin
        w_match = 1'b1;
      end
    end
  end

  assign o_conflict   = i_cmp_en & w_match;
  assign o_head_addr  = r_addr[r_head];
  assign o_head_value = r_value[r_head];
  assign o_count      = r_count;
  assign o_full       = r_full;
  assign o_empty      = (r_count == '0);

endmodule

// File: rtl/dcache_port_arb.sv
// Dcache request-port arbiter between LSQ loads and the retire-store buffer.
// Ports:
//   clock, reset        - clock, asynchronous active-low reset
//   ld_req/ld_*         - ready load from LSQ; ld_gnt accepts it (LSQ Dcache_avail)
//   st_push/st_*        - retired store entering the buffer
//   stb_full/stb_count  - buffer occupancy
//   mem_*               - registered request to Dcache, held until mem_ready
module dcache_port_arb
  import mem_pkg::*;
#(
  parameter int unsigned STB_DEPTH    = 4,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     ld_req,
  input  logic [MEM_ADDR_W-1:0]    ld_addr,
  input  logic [PR_IDX_W-1:0]      ld_pr_idx,
  input  logic [AR_IDX_W-1:0]      ld_ar_idx,
  output logic                     ld_gnt,
  input  logic                     st_push,
  input  logic [MEM_ADDR_W-1:0]    st_addr,
  input  logic [MEM_ADDR_W-1:0]    st_value,
  output logic                     stb_full,
  output logic [$clog2(STB_DEPTH):0] stb_count,
  output logic                     mem_valid,
  output logic                     mem_rd,
  output logic                     mem_wr,
  output logic [MEM_ADDR_W-1:0]    mem_addr,
  output logic [MEM_ADDR_W-1:0]    mem_value,
  output logic [PR_IDX_W-1:0]      mem_pr_idx,
  output logic [AR_IDX_W-1:0]      mem_ar_idx,
  input  logic                     mem_ready
);

  localparam int unsigned SC_W = $clog2(STARVE_LIMIT + 1);

  req_state_e            r_state, w_state_d;
  logic                  r_rd, w_rd_d;
  logic                  r_wr, w_wr_d;
  logic [MEM_ADDR_W-1:0] r_addr, w_addr_d;
  logic [MEM_ADDR_W-1:0] r_value, w_value_d;
  logic [PR_IDX_W-1:0]   r_pr, w_pr_d;
  logic [AR_IDX_W-1:0]   r_ar, w_ar_d;
  logic [SC_W-1:0]       r_starve, w_starve_d;

  logic                  w_port_free;
  logic                  w_st_pri;
  logic                  w_grant_ld;
  logic                  w_grant_st;
  logic                  w_conflict;
  logic                  w_empty;
  logic                  w_full;
  logic [MEM_ADDR_W-1:0] w_head_addr;
  logic [MEM_ADDR_W-1:0] w_head_value;

  stb_fifo #(
    .DEPTH(STB_DEPTH)
  ) u_stb (
    .clock        (clock),
    .reset        (reset),
    .i_push       (st_push),
    .i_push_addr  (st_addr),
    .i_push_value (st_value),
    .i_pop        (w_grant_st),
    .i_cmp_en     (ld_req),
    .i_cmp_qw     (ld_addr[MEM_ADDR_W-1:QW_LSB]),
    .o_head_addr  (w_head_addr),
    .o_head_value (w_head_value),
    .o_count      (stb_count),
    .o_full       (w_full),
    .o_empty      (w_empty),
    .o_conflict   (w_conflict)
  );

  assign w_port_free = (r_state == IDLE) | mem_ready;
  assign w_st_pri    = ~w_empty & (w_full | (r_starve == SC_W'(STARVE_LIMIT)) | w_conflict);

  // A conflicting load always implies a non-empty buffer, so st_pri blocks it.
  always_comb begin
    w_grant_ld = 1'b0;
    w_grant_st = 1'b0;
    if (w_port_free) begin
      if (w_st_pri)      w_grant_st = 1'b1;
      else if (ld_req)   w_grant_ld = 1'b1;
      else if (!w_empty) w_grant_st = 1'b1;
    end
  end

  assign ld_gnt = w_grant_ld & reset;

  always_comb begin
    w_state_d = r_state;
    w_rd_d    = r_rd;
    w_wr_d    = r_wr;
    w_addr_d  = r_addr;
    w_value_d = r_value;
    w_pr_d    = r_pr;
    w_ar_d    = r_ar;
    if (w_port_free) begin
      w_state_d = IDLE;
      w_rd_d    = 1'b0;
      w_wr_d    = 1'b0;
      w_addr_d  = '0;
      w_value_d = '0;
      w_pr_d    = '0;
      w_ar_d    = '0;
      if (w_grant_ld) begin
        w_state_d = LD_WAIT;
        w_rd_d    = 1'b1;
        w_addr_d  = ld_addr;
        w_pr_d    = ld_pr_idx;
        w_ar_d    = ld_ar_idx;
      end else if (w_grant_st) begin
        w_state_d = ST_WAIT;
        w_wr_d    = 1'b1;
        w_addr_d  = w_head_addr;
        w_value_d = w_head_value;
      end
    end
  end

  always_comb begin
    w_starve_d = r_starve;
    if (w_empty || w_grant_st)                w_starve_d = '0;
    else if (r_starve != SC_W'(STARVE_LIMIT)) w_starve_d = r_starve + 1'b1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state  <= IDLE;
      r_rd     <= 1'b0;
      r_wr     <= 1'b0;
      r_addr   <= '0;
      r_value  <= '0;
      r_pr     <= '0;
      r_ar     <= '0;
      r_starve <= '0;
    end else begin
      r_state  <= w_state_d;
      r_rd     <= w_rd_d;
      r_wr     <= w_wr_d;
      r_addr   <= w_addr_d;
      r_value  <= w_value_d;
      r_pr     <= w_pr_d;
      r_ar     <= w_ar_d;
      r_starve <= w_starve_d;
    end
  end

  assign stb_full   = w_full;
  assign mem_valid  = (r_state != IDLE);
  assign mem_rd     = r_rd;
  assign mem_wr     = r_wr;
  assign mem_addr   = r_addr;
  assign mem_value  = r_value;
  assign mem_pr_idx = r_pr;
  assign mem_ar_idx = r_ar;

endmodule

// File: tb/tb_dcache_port_arb.sv
module tb_dcache_port_arb;

  logic        clock;
  logic        reset;
  logic        ld_req;
  logic [63:0] ld_addr;
  logic [6:0]  ld_pr_idx;
  logic [4:0]  ld_ar_idx;
  logic        ld_gnt;
  logic        st_push;
  logic [63:0] st_addr;
  logic [63:0] st_value;
  logic        stb_full;
  logic [2:0]  stb_count;
  logic        mem_valid;
  logic        mem_rd;
  logic        mem_wr;
  logic [63:0] mem_addr;
  logic [63:0] mem_value;
  logic [6:0]  mem_pr_idx;
  logic [4:0]  mem_ar_idx;
  logic        mem_ready;

  int checks = 0;
  int errors = 0;

  dcache_port_arb #(
    .STB_DEPTH   (4),
    .STARVE_LIMIT(8)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .ld_req    (ld_req),
    .ld_addr   (ld_addr),
    .ld_pr_idx (ld_pr_idx),
    .ld_ar_idx (ld_ar_idx),
    .ld_gnt    (ld_gnt),
    .st_push   (st_push),
    .st_addr   (st_addr),
    .st_value  (st_value),
    .stb_full  (stb_full),
    .stb_count (stb_count),
    .mem_valid (mem_valid),
    .mem_rd    (mem_rd),
    .mem_wr    (mem_wr),
    .mem_addr  (mem_addr),
    .mem_value (mem_value),
    .mem_pr_idx(mem_pr_idx),
    .mem_ar_idx(mem_ar_idx),
    .mem_ready (mem_ready)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs;
    ld_req = 0; ld_addr = '0; ld_pr_idx = '0; ld_ar_idx = '0;
    st_push = 0; st_addr = '0; st_value = '0;
  endtask

  task automatic do_reset;
    idle_inputs();
    mem_ready = 1;
    reset = 0;
    tick();
    tick();
    reset = 1;
    tick();
  endtask

  task automatic test_reset;
    do_reset();
    reset = 0;
    ld_req = 1; ld_addr = 64'h40;
    #1;
    checks++;
    if ({mem_valid, mem_rd, mem_wr, stb_full, stb_count, ld_gnt} !== 8'b0) begin
      errors++;
      $display("FAIL reset_ctrl got v%b rd%b wr%b full%b cnt%0d gnt%b exp all 0",
               mem_valid, mem_rd, mem_wr, stb_full, stb_count, ld_gnt);
    end
    checks++;
    if ({mem_addr, mem_value, mem_pr_idx, mem_ar_idx} !== 140'b0) begin
      errors++;
      $display("FAIL reset_fields got addr %h val %h pr %0d ar %0d exp 0",
               mem_addr, mem_value, mem_pr_idx, mem_ar_idx);
    end
    idle_inputs();
    tick();
    reset = 1;
    tick();
  endtask

  task automatic test_load_only;
    do_reset();
    ld_req = 1; ld_addr = 64'h100; ld_pr_idx = 7'd12; ld_ar_idx = 5'd3;
    #1;
    checks++;
    if (ld_gnt !== 1'b1) begin
      errors++; $display("FAIL load_gnt got %b exp 1", ld_gnt);
    end
    tick();
    checks++;
    if ({mem_valid, mem_rd, mem_wr, mem_addr, mem_value, mem_pr_idx, mem_ar_idx} !==
        {1'b1, 1'b1, 1'b0, 64'h100, 64'h0, 7'd12, 5'd3}) begin
      errors++;
      $display("FAIL load_req got v%b rd%b wr%b addr %h val %h pr %0d ar %0d exp 1 1 0 100 0 12 3",
               mem_valid, mem_rd, mem_wr, mem_addr, mem_value, mem_pr_idx, mem_ar_idx);
    end
    ld_req = 0;
    tick();
    checks++;
    if ({mem_valid, mem_rd, mem_addr, mem_pr_idx} !== 73'b0) begin
      errors++;
      $display("FAIL load_idle got v%b rd%b addr %h pr %0d exp 0", mem_valid, mem_rd,
               mem_addr, mem_pr_idx);
    end
  endtask

  task automatic test_backpressure;
    do_reset();
    mem_ready = 0;
    ld_req = 1; ld_addr = 64'h180; ld_pr_idx = 7'd20; ld_ar_idx = 5'd4;
    #1;
    checks++;
    if (ld_gnt !== 1'b1) begin
      errors++; $display("FAIL bp_first_gnt got %b exp 1", ld_gnt);
    end
    tick();
    ld_addr = 64'h1C0; ld_pr_idx = 7'd21; ld_ar_idx = 5'd5;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if ({ld_gnt, mem_valid, mem_rd, mem_addr, mem_pr_idx, mem_ar_idx} !==
          {1'b0, 1'b1, 1'b1, 64'h180, 7'd20, 5'd4}) begin
        errors++;
        $display("FAIL bp_hold[%0d] got gnt%b v%b rd%b addr %h pr %0d ar %0d exp 0 1 1 180 20 4",
                 i, ld_gnt, mem_valid, mem_rd, mem_addr, mem_pr_idx, mem_ar_idx);
      end
      tick();
    end
    mem_ready = 1;
    #1;
    checks++;
    if ({ld_gnt, mem_addr} !== {1'b1, 64'h180}) begin
      errors++; $display("FAIL bp_release got gnt%b addr %h exp 1 180", ld_gnt, mem_addr);
    end
    tick();
    checks++;
    if ({mem_valid, mem_rd, mem_addr, mem_pr_idx} !== {1'b1, 1'b1, 64'h1C0, 7'd21}) begin
      errors++;
      $display("FAIL bp_next got v%b rd%b addr %h pr %0d exp 1 1 1c0 21", mem_valid, mem_rd,
               mem_addr, mem_pr_idx);
    end
    ld_req = 0;
    tick();
  endtask

  task automatic test_conflict;
    do_reset();
    st_push = 1; st_addr = 64'h208; st_value = 64'hDEAD;
    tick();
    st_push = 0;
    ld_req = 1; ld_addr = 64'h20C; ld_pr_idx = 7'd7; ld_ar_idx = 5'd1;
    #1;
    checks++;
    if ({ld_gnt, stb_count} !== {1'b0, 3'd1}) begin
      errors++; $display("FAIL conf_block got gnt%b cnt %0d exp 0 1", ld_gnt, stb_count);
    end
    tick();
    checks++;
    if ({mem_valid, mem_wr, mem_rd, mem_addr, mem_value, mem_pr_idx, stb_count} !==
        {1'b1, 1'b1, 1'b0, 64'h208, 64'hDEAD, 7'd0, 3'd0}) begin
      errors++;
      $display("FAIL conf_store got v%b wr%b rd%b addr %h val %h pr %0d cnt %0d exp 1 1 0 208 dead 0 0",
               mem_valid, mem_wr, mem_rd, mem_addr, mem_value, mem_pr_idx, stb_count);
    end
    #1;
    checks++;
    if (ld_gnt !== 1'b1) begin
      errors++; $display("FAIL conf_load_gnt got %b exp 1", ld_gnt);
    end
    tick();
    checks++;
    if ({mem_rd, mem_wr, mem_addr, mem_pr_idx} !== {1'b1, 1'b0, 64'h20C, 7'd7}) begin
      errors++;
      $display("FAIL conf_load got rd%b wr%b addr %h pr %0d exp 1 0 20c 7", mem_rd, mem_wr,
               mem_addr, mem_pr_idx);
    end
    ld_req = 0;
    tick();
  endtask

  task automatic test_starvation;
    logic [63:0] exp_addr;
    do_reset();
    st_push = 1; st_addr = 64'h400; st_value = 64'h44;
    ld_req = 1;
    for (int c = 0; c < 13; c++) begin
      ld_addr = 64'h1000 + 64'(c * 8);
      ld_pr_idx = 7'(c);
      #1;
      checks++;
      if (ld_gnt !== (c != 9)) begin
        errors++; $display("FAIL starve_gnt[%0d] got %b exp %b", c, ld_gnt, c != 9);
      end
      tick();
      st_push = 0;
      exp_addr = (c == 9) ? 64'h400 : 64'h1000 + 64'(c * 8);
      checks++;
      if ({mem_valid, mem_wr, mem_addr} !== {1'b1, c == 9, exp_addr}) begin
        errors++;
        $display("FAIL starve_req[%0d] got v%b wr%b addr %h exp 1 %b %h", c, mem_valid, mem_wr,
                 mem_addr, c == 9, exp_addr);
      end
    end
    ld_req = 0;
    tick();
  endtask

  task automatic test_full_wrap;
    int npush;
    logic [63:0] base;
    do_reset();
    for (int r = 0; r < 2; r++) begin
      npush = (r == 0) ? 6 : 4;
      base = (r == 0) ? 64'h0 : 64'h20;
      // Park a load in the port so pushes accumulate.
      mem_ready = 0;
      ld_req = 1; ld_addr = 64'h800; ld_pr_idx = 7'd1;
      tick();
      ld_req = 0;
      for (int i = 0; i < npush; i++) begin
        st_push = 1; st_addr = base + 64'(i * 8); st_value = 64'h100 + 64'(r * 16 + i);
        tick();
        checks++;
        if ({stb_count, stb_full} !== {3'((i < 3) ? i + 1 : 4), i >= 3}) begin
          errors++;
          $display("FAIL fill[%0d.%0d] got cnt %0d full %b exp %0d %b", r, i, stb_count,
                   stb_full, (i < 3) ? i + 1 : 4, i >= 3);
        end
      end
      st_push = 0;
      mem_ready = 1;
      for (int k = 0; k < 4; k++) begin
        tick();
        checks++;
        if ({mem_valid, mem_wr, mem_addr, mem_value} !==
            {1'b1, 1'b1, base + 64'(k * 8), 64'h100 + 64'(r * 16 + k)}) begin
          errors++;
          $display("FAIL drain[%0d.%0d] got v%b wr%b addr %h val %h exp 1 1 %h %h", r, k,
                   mem_valid, mem_wr, mem_addr, mem_value, base + 64'(k * 8),
                   64'h100 + 64'(r * 16 + k));
        end
      end
      tick();
      checks++;
      if ({mem_valid, stb_count} !== 4'b0) begin
        errors++;
        $display("FAIL drain_done[%0d] got v%b cnt %0d exp 0 0", r, mem_valid, stb_count);
      end
    end
  endtask

  task automatic test_reset_mid;
    do_reset();
    mem_ready = 0;
    for (int i = 0; i < 3; i++) begin
      st_push = 1; st_addr = 64'h600 + 64'(i * 8); st_value = 64'(i);
      tick();
    end
    st_push = 0;
    checks++;
    if ({mem_valid, mem_wr, mem_addr, stb_count} !== {1'b1, 1'b1, 64'h600, 3'd2}) begin
      errors++;
      $display("FAIL mid_setup got v%b wr%b addr %h cnt %0d exp 1 1 600 2", mem_valid, mem_wr,
               mem_addr, stb_count);
    end
    ld_req = 1; ld_addr = 64'h900;
    #2;
    reset = 0;
    #1;
    checks++;
    if ({mem_valid, mem_wr, stb_count, stb_full, ld_gnt, mem_addr} !== 71'b0) begin
      errors++;
      $display("FAIL mid_reset got v%b wr%b cnt %0d full %b gnt %b addr %h exp all 0",
               mem_valid, mem_wr, stb_count, stb_full, ld_gnt, mem_addr);
    end
    ld_req = 0;
    mem_ready = 1;
    tick();
    reset = 1;
    tick();
    tick();
    checks++;
    if ({mem_valid, stb_count} !== 4'b0) begin
      errors++;
      $display("FAIL mid_after got v%b cnt %0d exp 0 0", mem_valid, stb_count);
    end
    ld_req = 1; ld_addr = 64'h940; ld_pr_idx = 7'd9;
    #1;
    checks++;
    if (ld_gnt !== 1'b1) begin
      errors++; $display("FAIL mid_new_gnt got %b exp 1", ld_gnt);
    end
    tick();
    checks++;
    if ({mem_valid, mem_rd, mem_addr, mem_pr_idx} !== {1'b1, 1'b1, 64'h940, 7'd9}) begin
      errors++;
      $display("FAIL mid_new_req got v%b rd%b addr %h pr %0d exp 1 1 940 9", mem_valid, mem_rd,
               mem_addr, mem_pr_idx);
    end
    ld_req = 0;
    tick();
  endtask

  initial begin
    test_reset();
    test_load_only();
    test_backpressure();
    test_conflict();
    test_starvation();
    test_full_wrap();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dcache_port_arb.md
# dcache_port_arb

- Shares the single Dcache request port between two requesters: ready loads leaving the load/store queue, and retired stores drained from a small retire-store buffer.
- Sits between the LSQ and the Dcache.
- Supplies the LSQ's `Dcache_avail` grant.
- Preserves memory ordering: a load never overtakes a buffered store to the same quadword.
- Keeps stores from starving behind a steady load stream.

## Interface
- `STB_DEPTH`, 4: retire-store buffer entries (power of two, ≥2).
- `STARVE_LIMIT`, 8: consecutive cycles a non-empty buffer may lose arbitration before stores take priority.
- `clock` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low.
- `ld_req` in 1: LSQ has a ready load to send to cache.
- `ld_addr` in 64: load address.
- `ld_pr_idx` in 7: load destination physical register.
- `ld_ar_idx` in 5: load destination architectural register.
- `ld_gnt` out 1: load accepted this cycle; LSQ frees the entry (drives LSQ `Dcache_avail`).
- `st_push` in 1: a retired store enters the buffer.
- `st_addr` in 64: store address.
- `st_value` in 64: store data.
- `stb_full` out 1: buffer full; ROB must not retire a store.
- `stb_count` out $clog2(STB_DEPTH)+1: occupied entries.
- `mem_valid` out 1: request presented to Dcache.
- `mem_rd` out 1: request is a load.
- `mem_wr` out 1: request is a store.
- `mem_addr` out 64: request address.
- `mem_value` out 64: store data; 0 for loads.
- `mem_pr_idx` out 7: load tag; 0 for stores.
- `mem_ar_idx` out 5: load tag; 0 for stores.
- `mem_ready` in 1: Dcache accepts the presented request at this edge.

## Operation
- Port free: `port_free = ~mem_valid | mem_ready`.
- Conflict: `conflict` = `ld_req` and `ld_addr[63:3]` equals `addr[63:3]` of any valid buffer entry.
- Store priority: `st_pri` = buffer non-empty and (`stb_full` or `starve_cnt == STARVE_LIMIT` or `conflict`).
- Arbitration, combinational, only when `port_free`:
  - `st_pri`: grant store.
  - else if `ld_req`: grant load, `ld_gnt=1`.
  - else if buffer non-empty: grant store.
  - else: idle.
- `ld_gnt` is 0 whenever `conflict` or `~port_free`.
- Granted load: the output register loads rd=1, wr=0, addr, pr/ar tags, value=0.
- Granted store: the output register loads the buffer head (rd=0, wr=1, tags=0), and the head pops the same edge.
- No grant and `mem_ready` high: `mem_valid` clears and all request fields go to 0.
- Request state: a 3-state FSM in the output register.
  - IDLE → LD_WAIT or ST_WAIT on a grant.
  - LD_WAIT/ST_WAIT hold all fields stable until `mem_ready`.
  - On `mem_ready`, move to the next grant's state or return to IDLE.
  - `mem_valid` = state ≠ IDLE.
- Buffer: circular FIFO with head/tail pointers of `$clog2(STB_DEPTH)` bits; wrap is modulo `STB_DEPTH`.
  - Push and pop in the same cycle leave `stb_count` unchanged.
  - A push while `stb_full` is dropped and is a bench assertion error.
  - A push into an empty buffer is not visible to arbitration until the next cycle.
- `starve_cnt` (width holds `STARVE_LIMIT`):
  - Increments each cycle the buffer is non-empty and no store is granted.
  - Saturates at `STARVE_LIMIT`.
  - Clears on store grant or when the buffer is empty.
- Reset values:
  - `mem_valid`, `mem_rd`, `mem_wr` = 0; `mem_addr`, `mem_value`, `mem_pr_idx`, `mem_ar_idx` = 0.
  - `stb_count` = 0, `stb_full` = 0, `starve_cnt` = 0, FSM = IDLE.
  - `ld_gnt` is forced to 0 while `reset` is low.
- Reset mid-operation: the in-flight request and all buffered stores are discarded; no partial state survives.

## Timing
- Grant to `mem_valid`: one cycle (registered).
- Back-to-back: a new grant is allowed in the same cycle as `mem_ready`, so sustained throughput is one request per cycle.
- `stb_full` and `stb_count` are registered; `ld_gnt` is combinational from registered state plus `ld_*` inputs.
- Store latency, `st_push` to earliest `mem_valid` with wr=1: 2 cycles (push edge, then grant edge).
- Worst-case store wait under continuous loads with `mem_ready` held high: `STARVE_LIMIT`+1 cycles.

## Structure
- Shared package `mem_pkg`:
  - Request-type encoding (IDLE/LD_WAIT/ST_WAIT).
  - `MEM_ADDR_W=64`, `PR_IDX_W=7`, `AR_IDX_W=5`.
  - Quadword offset constant `QW_LSB=3`.
- Sub-module `stb_fifo`:
  - Storage, pointers, count and full flag.
  - Parallel quadword-address compare port returning `conflict`.
- Arbiter, starvation counter and output FSM stay in `dcache_port_arb`.

## Test plan
- Load only: `ld_req=1`, `addr=0x100`, `pr=12`, `mem_ready=1` → `ld_gnt=1` cycle 0; next cycle `mem_valid=1`, rd=1, addr `0x100`, pr 12.
- Backpressure: grant a load with `mem_ready=0` for 3 cycles → fields stable for 3 cycles, `ld_gnt=0` throughout, new grant in the cycle `mem_ready=1`.
- Conflict: push store `0x208`, then `ld_req` `0x20C` → `ld_gnt=0`; store issues first (wr=1, addr `0x208`); load granted the cycle after the buffer empties.
- Starvation: push one store at `0x400`, hold `ld_req` with distinct addresses, `mem_ready=1` → store granted on cycle `STARVE_LIMIT`+1 after push, then loads resume.
- Full/wrap: 6 pushes with `mem_ready=0` → `stb_full=1` after 4 pushes, `stb_count=4`, remaining 2 pushes dropped; release `mem_ready` → drain order `0x0`,`0x8`,`0x10`,`0x18`; refill 4 and drain again in push order.
- Reset: assert `reset` low while ST_WAIT with 2 entries buffered → same instant `mem_valid=0`, `stb_count=0`, `ld_gnt=0`; after release, idle until new requests.
